// File: rtl/merac_core_if.sv
// Instruction and data memory ports of the MERAC core: valid/ack request pairs with data.
// The core is the master; a request holds its address and data steady until acked.
interface merac_core_if #(
    parameter int WORD_W = 8
);
    localparam int ADDR_W = 2 * WORD_W;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/merac_core.sv
// MERAC multi-cycle core: 4 cycles per instruction (5 for LD/ST) with zero-wait memories.
// Backpressure: FETCH and MEM hold their request stable until the matching ack arrives.
module merac_core #(
    parameter int WORD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    merac_core_if.master        mem,
    output logic                halted,
    output logic                retire,
    output logic [2*WORD_W-1:0] dbg_pc
);
    localparam int ADDR_W = 2 * WORD_W;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, STOREPC, HALT} state_t;

    state_t            state, state_nx;
    logic [WORD_W-1:0] rf [16];
    logic [15:0]       ir;
    logic [WORD_W-1:0] op_a, op_b, op_d;
    logic [ADDR_W-1:0] npc_q;

    logic [3:0]        opc, dst, s0, s1;
    logic [ADDR_W-1:0] pc, pair, pc_p2, pc_p4, exec_npc;
    logic [WORD_W:0]   sum_x;
    logic              wr0_en, wr1_en;
    logic [3:0]        wr0_idx, wr1_idx;
    logic [WORD_W-1:0] wr0_val, wr1_val;

    assign opc   = ir[15:12];
    assign dst   = ir[11:8];
    assign s0    = ir[7:4];
    assign s1    = ir[3:0];
    assign pc    = {rf[15], rf[14]};
    assign pair  = {op_b, op_a};
    assign pc_p2 = pc + ADDR_W'(2);
    assign pc_p4 = pc + ADDR_W'(4);
    assign sum_x = {1'b0, op_a} + {1'b0, op_b};

    // Execute: up to two register writes plus the next PC, all from the latched operands.
    always_comb begin
        wr0_en   = 1'b0;
        wr0_idx  = dst;
        wr0_val  = '0;
        wr1_en   = 1'b0;
        wr1_idx  = dst + 4'd1;
        wr1_val  = op_b;
        exec_npc = pc_p2;
        case (opc)
            4'h4: begin wr0_en = 1'b1; wr0_val = WORD_W'(ir[7:0]); end
            4'h5: begin
                wr0_en   = 1'b1;
                wr0_idx  = 4'd12;
                wr0_val  = pc_p2[WORD_W-1:0];
                wr1_en   = 1'b1;
                wr1_idx  = 4'd13;
                wr1_val  = pc_p2[ADDR_W-1:WORD_W];
                exec_npc = pair;
            end
            4'h6: begin
                wr0_en  = 1'b1;
                wr0_val = op_a;
                wr1_en  = 1'b1;
                if (dst >= 4'd14) exec_npc = pair;
            end
            4'h7: if (op_a != op_b) exec_npc = pc_p4;
            4'h8: begin wr0_en = 1'b1; wr0_val = sum_x[WORD_W-1:0]; end
            4'h9: begin wr0_en = 1'b1; wr0_val = op_a - op_b; end
            4'hA: begin wr0_en = 1'b1; wr0_val = op_a & op_b; end
            4'hB: begin wr0_en = 1'b1; wr0_val = op_a | op_b; end
            4'hC: begin wr0_en = 1'b1; wr0_val = ~op_a; end
            4'hD: begin wr0_en = 1'b1; wr0_val = op_a; end
            4'hE: if (op_a >= op_b) exec_npc = pc_p4;
            4'hF: if (!sum_x[WORD_W]) exec_npc = pc_p4;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        retire       = 1'b0;
        halted       = 1'b0;
        case (state)
            FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) state_nx = DECODE;
            end
            DECODE: state_nx = EXEC;
            EXEC: begin
                if (opc == 4'h2 || opc == 4'h3) state_nx = MEM;
                else if (opc == 4'h1)           state_nx = HALT;
                else                            state_nx = STOREPC;
            end
            MEM: begin
                mem.dmem_req = 1'b1;
                if (mem.dmem_ack) state_nx = STOREPC;
            end
            STOREPC: begin
                retire   = 1'b1;
                state_nx = FETCH;
            end
            HALT:    halted = 1'b1;
            default: state_nx = FETCH;
        endcase
    end

    // Writes aimed at r14/r15 are dropped: the PC update in STOREPC owns that pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            ir    <= '0;
            op_a  <= '0;
            op_b  <= '0;
            op_d  <= '0;
            npc_q <= '0;
        end else begin
            case (state)
                FETCH: if (mem.imem_ack) ir <= mem.imem_rdata;
                DECODE: begin
                    op_a <= rf[s0];
                    op_b <= rf[s1];
                    op_d <= rf[dst];
                end
                EXEC: begin
                    npc_q <= exec_npc;
                    if (wr0_en && wr0_idx < 4'd14) rf[wr0_idx] <= wr0_val;
                    if (wr1_en && wr1_idx < 4'd14) rf[wr1_idx] <= wr1_val;
                end
                MEM: if (mem.dmem_ack && opc == 4'h2 && dst < 4'd14) rf[dst] <= mem.dmem_rdata;
                STOREPC: begin
                    rf[15] <= npc_q[ADDR_W-1:WORD_W];
                    rf[14] <= npc_q[WORD_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign mem.imem_addr  = pc;
    assign mem.dmem_we    = (state == MEM) && (opc == 4'h3);
    assign mem.dmem_addr  = pair;
    assign mem.dmem_wdata = mem.dmem_we ? op_d : '0;
    assign dbg_pc         = pc;
endmodule

// File: tb/tb_merac_core.sv
// Bench for merac_core: an ISA-level model predicts fetches, data transactions and final state;
// memory responders pop those predictions whenever the core completes a request.
module tb_merac_core;
    typedef struct {
        bit              we;
        longint unsigned addr;
        longint unsigned wdata;
    } dtx_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic rst16_n = 1'b1;
    always #5 clk = ~clk;

    logic        halted, retire, halted16, retire16;
    logic [15:0] dbg_pc;
    logic [31:0] dbg_pc16;

    merac_core_if #(.WORD_W(8))  bus ();
    merac_core_if #(.WORD_W(16)) bus16 ();

    merac_core #(.WORD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem(bus),
        .halted(halted), .retire(retire), .dbg_pc(dbg_pc)
    );
    merac_core #(.WORD_W(16)) dut16 (
        .clk(clk), .rst_n(rst16_n), .mem(bus16),
        .halted(halted16), .retire(retire16), .dbg_pc(dbg_pc16)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0]     prog [32768];
    longint unsigned m_r [16];
    longint unsigned m_pc;
    int              m_ret, m_mem;
    longint unsigned exp_f[$];
    dtx_t            exp_d[$];
    logic [7:0]      dmem_tb [int];
    int  imode = 0, dmode = 0;
    bit  stall_i = 0, stall_d = 0, sb_on = 0;
    int  ret_cnt = 0;
    int  icnt = 0, dcnt = 0, idly = 0, ddly = 0;
    logic [15:0] ilast, dlast;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pick(int mode);
        case (mode)
            0:       return 0;
            1:       return 3;
            default: return $urandom_range(0, 4);
        endcase
    endfunction

    // Architectural reference: one loop iteration per instruction, plain integer arithmetic.
    task automatic model_run(input int w, input int max_steps, output bit ok);
        longint unsigned mask, amask, pc, a, b, d, p, npc;
        longint unsigned dmod [longint unsigned];
        logic [15:0] ins;
        int opc, dst, s0, s1;
        mask  = (64'd1 << w) - 1;
        amask = (64'd1 << (2 * w)) - 1;
        for (int i = 0; i < 16; i++) m_r[i] = 0;
        m_ret = 0; m_mem = 0; m_pc = 0; ok = 0; pc = 0;
        exp_f.delete(); exp_d.delete();
        for (int step = 0; step < max_steps; step++) begin
            ins = prog[(pc >> 1) & 32767];
            exp_f.push_back(pc);
            opc = int'(ins[15:12]); dst = int'(ins[11:8]); s0 = int'(ins[7:4]); s1 = int'(ins[3:0]);
            a = m_r[s0]; b = m_r[s1]; d = m_r[dst];
            p = (b << w) | a;
            npc = (pc + 2) & amask;
            case (opc)
                1: begin m_pc = pc; ok = 1; return; end
                2: begin
                    exp_d.push_back('{0, p, 0});
                    if (dst < 14) m_r[dst] = dmod.exists(p) ? dmod[p] : 0;
                    m_mem++;
                end
                3: begin dmod[p] = d; exp_d.push_back('{1, p, d}); m_mem++; end
                4: if (dst < 14) m_r[dst] = longint'(ins[7:0]);
                5: begin m_r[12] = npc & mask; m_r[13] = (npc >> w) & mask; npc = p; end
                6: begin
                    if (dst < 14) m_r[dst] = a;
                    if ((dst + 1) % 16 < 14) m_r[(dst + 1) % 16] = b;
                    if (dst >= 14) npc = p;
                end
                7:  if (a != b) npc = (pc + 4) & amask;
                8:  if (dst < 14) m_r[dst] = (a + b) & mask;
                9:  if (dst < 14) m_r[dst] = (a - b) & mask;
                10: if (dst < 14) m_r[dst] = a & b;
                11: if (dst < 14) m_r[dst] = a | b;
                12: if (dst < 14) m_r[dst] = (~a) & mask;
                13: if (dst < 14) m_r[dst] = a;
                14: if (a >= b) npc = (pc + 4) & amask;
                15: if (((a + b) >> w) == 0) npc = (pc + 4) & amask;
                default: ;
            endcase
            m_ret++;
            pc = npc;
            m_r[14] = pc & mask;
            m_r[15] = (pc >> w) & mask;
        end
    endtask

    // Memory responders and scoreboard monitor for the 8-bit core.
    always @(negedge clk) begin
        if (!rst_n) begin
            ret_cnt = 0;
            dmem_tb.delete();
        end else if (retire) begin
            ret_cnt++;
        end
        if (bus.imem_req && rst_n) begin
            if (icnt == 0) idly = pick(imode);
            else if (sb_on) check("imem_addr_stable", 64'(bus.imem_addr), 64'(ilast));
            ilast = bus.imem_addr;
            if (!stall_i && icnt >= idly) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = prog[bus.imem_addr[15:1]];
                if (sb_on) begin
                    if (exp_f.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL fetch_extra actual=%0h required=none", bus.imem_addr);
                    end else check("fetch_addr", 64'(bus.imem_addr), exp_f.pop_front());
                end
                icnt = 0;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 16'($urandom);
                icnt++;
            end
        end else begin
            icnt = 0;
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = 16'($urandom);
        end
        if (bus.dmem_req && rst_n) begin
            if (dcnt == 0) ddly = pick(dmode);
            else if (sb_on) check("dmem_addr_stable", 64'(bus.dmem_addr), 64'(dlast));
            dlast = bus.dmem_addr;
            if (!stall_d && dcnt >= ddly) begin
                dtx_t t;
                bus.dmem_ack = 1'b1;
                if (bus.dmem_we) begin
                    dmem_tb[int'(bus.dmem_addr)] = bus.dmem_wdata;
                    bus.dmem_rdata = 8'($urandom);
                end else begin
                    bus.dmem_rdata = dmem_tb.exists(int'(bus.dmem_addr)) ? dmem_tb[int'(bus.dmem_addr)] : 8'h00;
                end
                if (sb_on) begin
                    if (exp_d.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL dmem_extra actual=%0h required=none", bus.dmem_addr);
                    end else begin
                        t = exp_d.pop_front();
                        check("dmem_we", 64'(bus.dmem_we), 64'(t.we));
                        check("dmem_addr", 64'(bus.dmem_addr), t.addr);
                        check("dmem_wdata", 64'(bus.dmem_wdata), t.wdata);
                    end
                end
                dcnt = 0;
            end else begin
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = 8'($urandom);
                dcnt++;
            end
        end else begin
            dcnt = 0;
            bus.dmem_ack   = 1'($urandom_range(0, 1));
            bus.dmem_rdata = 8'($urandom);
        end
    end

    // The 16-bit core sees zero-wait memories.
    always @(negedge clk) begin
        bus16.imem_ack   = 1'b1;
        bus16.imem_rdata = prog[bus16.imem_addr[15:1]];
        bus16.dmem_ack   = 1'b1;
        bus16.dmem_rdata = 16'h0000;
    end

    task automatic load_img(input logic [15:0] img[$]);
        for (int i = 0; i < 32768; i++) prog[i] = 16'h1000;
        for (int i = 0; i < img.size(); i++) prog[i] = img[i];
    endtask

    task automatic run_prog(input int im, input int dm);
        bit ok;
        int cyc;
        model_run(8, 400, ok);
        imode = im; dmode = dm; stall_i = 0; stall_d = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        sb_on = 1;
        #1 rst_n = 1'b1;
        cyc = 0;
        while (!halted && cyc < 8000) begin @(negedge clk); cyc++; end
        repeat (4) @(negedge clk);
        check("halted", 64'(halted), 64'd1);
        if (im == 0 && dm == 0) check("cycles", 64'(cyc), 64'(4 * m_ret + m_mem + 4));
        check("retire_count", 64'(ret_cnt), 64'(m_ret));
        check("dbg_pc", 64'(dbg_pc), m_pc);
        check("fetch_left", 64'(exp_f.size()), 64'd0);
        check("dmem_left", 64'(exp_d.size()), 64'd0);
        for (int i = 0; i < 16; i++) check($sformatf("r%0d", i), 64'(dut.rf[i]), m_r[i]);
        sb_on = 0;
    endtask

    task automatic abort_run(input bit on_d);
        int n;
        sb_on = 0; imode = 0; dmode = 0; stall_i = 0; stall_d = on_d;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        if (!on_d) begin
            repeat (30) @(negedge clk);
            stall_i = 1;
        end
        n = 0;
        while (!(on_d ? bus.dmem_req : (bus.imem_req && bus.imem_addr != 0)) && n < 200) begin
            @(negedge clk); n++;
        end
        repeat (2) @(negedge clk);
        if (on_d) check("abort_dreq_pre", 64'(bus.dmem_req), 64'd1);
        else      check("abort_iaddr_pre", 64'(bus.imem_addr != 0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        if (on_d) check("abort_dreq", 64'(bus.dmem_req), 64'd0);
        check("abort_ireq", 64'(bus.imem_req), 64'd1);
        check("abort_iaddr", 64'(bus.imem_addr), 64'd0);
        @(negedge clk);
        stall_i = 0; stall_d = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] img[$];
        bit ok;
        int tries, cyc;
        #1 rst_n = 1'b0; rst16_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_imem_req", 64'(bus.imem_req), 64'd1);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
        check("rst_dmem_we", 64'(bus.dmem_we), 64'd0);
        check("rst_dmem_wdata", 64'(bus.dmem_wdata), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);
        for (int i = 0; i < 16; i++) check($sformatf("rst_r%0d", i), 64'(dut.rf[i]), 64'd0);

        img = '{16'h4108, 16'h420A, 16'h4300, 16'h4401, 16'h8334, 16'hE032, 16'h6E10, 16'h1000};
        load_img(img);
        run_prog(0, 0);
        check("loop_r3", 64'(dut.rf[3]), 64'd10);
        check("loop_retires", 64'(ret_cnt), 64'd33);
        check("loop_pc", 64'(dbg_pc), 64'd14);
        run_prog(1, 2);
        check("loop_wait_r3", 64'(dut.rf[3]), 64'd10);
        check("loop_wait_retires", 64'(ret_cnt), 64'd33);
        check("loop_wait_pc", 64'(dbg_pc), 64'd14);
        abort_run(0);

        img = '{16'h4534, 16'h4740, 16'h3570, 16'h2870, 16'h1000};
        load_img(img);
        run_prog(2, 2);
        check("mem_r8", 64'(dut.rf[8]), 64'h34);
        abort_run(1);

        img = '{16'h4050, 16'h4100, 16'h4220, 16'h4300, 16'h6E23};
        load_img(img);
        prog[16] = 16'h5001;
        run_prog(0, 0);
        check("call_r12", 64'(dut.rf[12]), 64'h22);
        check("call_r13", 64'(dut.rf[13]), 64'h0);
        check("call_pc", 64'(dbg_pc), 64'h50);

        for (int k = 0; k < 8; k++) begin
            tries = 0;
            do begin
                for (int i = 0; i < 32768; i++) prog[i] = 16'h1000;
                for (int i = 0; i < 24; i++) prog[i] = 16'($urandom);
                model_run(8, 300, ok);
                tries++;
            end while (!ok && tries < 50);
            run_prog($urandom_range(0, 2), $urandom_range(0, 2));
        end

        img = '{16'hC100, 16'h4201, 16'hF012, 16'h4507, 16'h8412, 16'h1000};
        load_img(img);
        model_run(16, 100, ok);
        @(posedge clk);
        #1 rst16_n = 1'b1;
        cyc = 0;
        while (!halted16 && cyc < 500) begin @(negedge clk); cyc++; end
        check("w16_halted", 64'(halted16), 64'd1);
        check("w16_cycles", 64'(cyc), 64'(4 * 5 + 4));
        check("w16_r1", 64'(dut16.rf[1]), 64'hFFFF);
        check("w16_r4", 64'(dut16.rf[4]), 64'h0);
        check("w16_r5", 64'(dut16.rf[5]), 64'h7);
        check("w16_pc", 64'(dbg_pc16), 64'd10);
        for (int i = 0; i < 16; i++) check($sformatf("w16_r%0d", i), 64'(dut16.rf[i]), m_r[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/merac_core.md
# merac_core

Parametrised multi-cycle successor to the first MERAC core: the same 16-register, 16-bit-instruction machine, with the program counter held in r14 (low) and r15 (high). This generation adds a configurable data word width, asynchronous active-low reset and separate valid/ack instruction and data memory ports that tolerate any number of wait states. It implements ST, CALL and CND, and exports halted, retire and dbg_pc status for the system bench.

## Interface
- WORD_W, 8: register and data width (≥8); ADDR_W = 2*WORD_W is derived, not a parameter.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request; high exactly while state = FETCH.
- imem_addr  out  ADDR_W  fetch address = {r15,r14}.
- imem_ack  in  1  fetch completes at a rising edge where req and ack are both high.
- imem_rdata  in  16  instruction, sampled at the completing edge.
- dmem_req  out  1  data request; high exactly while state = MEM.
- dmem_we  out  1  1 = store (ST), 0 = load (LD); valid while dmem_req.
- dmem_addr  out  ADDR_W  {R[s1],R[s0]}.
- dmem_wdata  out  WORD_W  R[dst] for ST; otherwise 0.
- dmem_rdata  in  WORD_W  load data, sampled at the completing edge.
- dmem_ack  in  1  same completion rule as imem_ack.
- halted  out  1  high from the edge that executes HLT until reset.
- retire  out  1  high for one cycle per retired instruction (state STOREPC).
- dbg_pc  out  ADDR_W  {r15,r14}.

## Operation
- Instruction fields: opc = [15:12], dst = [11:8], s0 = [7:4], s1 = [3:0], imm = [7:0] (zero-extended). Pair operand P = {R[s1],R[s0]}.
- Opcodes:
  - 0 NOP.
  - 1 HLT.
  - 2 LD: R[dst] ← mem[P].
  - 3 ST: mem[P] ← R[dst].
  - 4 MVC: R[dst] ← imm.
  - 5 CALL: {r13,r12} ← PC+2, PC ← P.
  - 6 MVD: R[dst] ← R[s0], R[(dst+1) mod 16] ← R[s1]; if dst ≥ 14 then PC ← P.
  - 7 EQ: skip if R[s0] ≠ R[s1].
  - 8 ADD, 9 SUB (s0−s1), A AND, B OR: R[dst] ← R[s0] op R[s1], modulo 2^WORD_W.
  - C NOT: R[dst] ← ~R[s0].
  - D MV: R[dst] ← R[s0].
  - E LT: skip if R[s0] ≥ R[s1] (unsigned).
  - F CND: skip unless R[s0]+R[s1] carries out of WORD_W.
- Skip: PC ← PC+4. Normal: PC ← PC+2. All PC arithmetic is modulo 2^ADDR_W.
- PC update at STOREPC overrides any LD/MVC/ALU write to r14 or r15; those writes are discarded. For MVD with dst = 15, r0 is still written with R[s1].
- States:
  - FETCH: wait for imem_ack, then go to DECODE.
  - DECODE: register reads, then EXEC.
  - EXEC: go to MEM for LD/ST, HALT for HLT, otherwise STOREPC.
  - MEM: wait for dmem_ack, then STOREPC.
  - STOREPC: write PC, assert retire, go to FETCH.
  - HALT: terminal until reset.
- HLT does not retire and does not advance the PC; dbg_pc holds the HLT address.
- Reset: all 16 registers = 0, state = FETCH, halted = 0, retire = 0, dmem_req = 0, dmem_we = 0, dmem_wdata = 0. imem_req is high from reset exit, with imem_addr = 0.

## Timing
- With ack tied high: non-memory instructions take 4 cycles (FETCH, DECODE, EXEC, STOREPC); LD and ST take 5.
- Each wait cycle on an ack adds 1 cycle. Address, we and wdata stay stable while req is high.
- req falls in the cycle after the completing edge. There is exactly one transaction per FETCH or MEM visit, and ack without req is ignored.
- Reset asserted mid-transaction drops dmem_req immediately and abandons the transaction; imem_req stays high but the fetch address is forced to 0. Late acks and data for the abandoned transaction are ignored.
- A load result is visible in the register file from the STOREPC cycle onward.

## Test plan
- Reset: hold rst_n = 0 with random acks → all registers 0, dmem_req = 0, halted = 0, retire = 0, imem_req = 1 with imem_addr = 0. After release, the first fetch is from 0.
- Loop program, acks tied high:
  - 0: MVC r1,#8; 2: MVC r2,#10; 4: MVC r3,#0; 6: MVC r4,#1
  - 8: ADD r3,r3,r4; 10: LT r3,r2; 12: MVD r14,r1,r0; 14: HLT
  - Expected: r3 = 10, halted = 1, dbg_pc = 14, exactly 33 retire pulses.
- Same program with imem_ack delayed 3 cycles and random dmem_ack delays → identical final state; imem_addr stays stable while imem_req is high.
- Memory:
  - Program: MVC r5,#0x34; MVC r7,#0x40; ST r5,r7,r0; LD r8,r7,r0.
  - Expected: one write (we = 1, addr 0x0040, wdata 0x34), then one read returning 0x34 → r8 = 0x34.
- CALL at address 0x20 with r0 = 0x50, r1 = 0 → r12 = 0x22, r13 = 0, next fetch at 0x0050.
- WORD_W = 16: r1 = 0xFFFF, r2 = 1, CND r1,r2 → next instruction not skipped; ADD gives 0. Reset asserted during a stalled fetch → fetch address forced to 0, and after release the fetch restarts at 0.
